// File: rtl/syzygy_adc_align_ctrl.sv
// Reset sequencing and frame-word alignment for the SYZYGY LTC226x ADC front end.
// Define SYZYGY_ADC_ALIGN_STATS_EN to add the slip_total / relock_cnt statistics outputs.
module syzygy_adc_align_ctrl #(
    parameter int                NUM_CH        = 2,
    parameter int                WORD_W        = 16,
    parameter logic [WORD_W-1:0] FRAME_PATTERN = 16'hFF00,
    parameter int                SERDES_WAIT   = 64,
    parameter int                SETTLE_CYC    = 4,
    parameter int                MATCH_CNT     = 4,
    parameter int                LOSS_CNT      = 4
) (
    input  logic                       adc_data_clk,
    input  logic                       reset_async,
    input  logic                       mmcm_locked,
    input  logic                       idelay_rdy,
    input  logic [WORD_W-1:0]          frame_word,
    input  logic [NUM_CH*WORD_W-1:0]   adc_data_in,
    input  logic                       retrain,
    output logic                       reset_sync,
    output logic                       reset_idelay,
    output logic                       bitslip,
    output logic [$clog2(WORD_W)-1:0]  bitslip_count,
    output logic                       rdy,
    output logic [NUM_CH*WORD_W-1:0]   adc_data_out,
    output logic                       data_valid,
`ifdef SYZYGY_ADC_ALIGN_STATS_EN
    output logic [15:0]                slip_total,
    output logic [7:0]                 relock_cnt,
`endif
    output logic                       align_err
);

    localparam int WAIT_W  = $clog2(SERDES_WAIT + 1);
    localparam int SET_W   = $clog2(SETTLE_CYC + 1);
    localparam int MATCH_W = $clog2(MATCH_CNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_CNT + 1);
    localparam int ATT_W   = $clog2(WORD_W + 1);
    localparam int CNT_W   = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_RESET, S_WAIT_DLY, S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_ERROR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [MATCH_W-1:0] match_cnt;
    logic [LOSS_W-1:0]  loss_cnt;
    logic [ATT_W-1:0]   attempt_cnt;
    logic               frame_match;
    logic               training;
    logic               restart;
    logic               lock_lost;

    assign frame_match = (frame_word == FRAME_PATTERN);
    assign training    = state inside {S_CHECK, S_SLIP, S_SETTLE, S_LOCKED, S_ERROR};
    // Clock loss outranks retrain, so restart only counts while the MMCM is locked.
    assign restart     = mmcm_locked && retrain && training;
    assign lock_lost   = (state == S_LOCKED) && (state_next == S_CHECK) && !restart;

    always_ff @(posedge adc_data_clk or posedge reset_async) begin
        if (reset_async) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state != S_RESET && !mmcm_locked) begin
            state_next = S_RESET;
        end else if (restart) begin
            state_next = S_CHECK;
        end else begin
            case (state)
                S_RESET:    if (mmcm_locked) state_next = S_WAIT_DLY;
                S_WAIT_DLY: if (wait_cnt == '0) state_next = S_CHECK;
                S_CHECK: begin
                    if (!frame_match) begin
                        state_next = S_SLIP;
                    end else if (match_cnt == MATCH_W'(MATCH_CNT - 1)) begin
                        state_next = S_LOCKED;
                    end
                end
                S_SLIP: begin
                    if (attempt_cnt == ATT_W'(WORD_W - 1)) state_next = S_ERROR;
                    else                                    state_next = S_SETTLE;
                end
                S_SETTLE:   if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_next = S_CHECK;
                S_LOCKED:   if (!frame_match && loss_cnt == LOSS_W'(LOSS_CNT - 1)) state_next = S_CHECK;
                S_ERROR:    state_next = S_ERROR;
                default:    state_next = S_RESET;
            endcase
        end
    end

    always_comb begin
        reset_sync   = (state == S_RESET);
        reset_idelay = (state == S_RESET);
        rdy          = training;
        bitslip      = (state == S_SLIP);
        data_valid   = (state == S_LOCKED);
        align_err    = (state == S_ERROR);
    end

    always_ff @(posedge adc_data_clk or posedge reset_async) begin
        if (reset_async) begin
            wait_cnt      <= '0;
            settle_cnt    <= '0;
            match_cnt     <= '0;
            loss_cnt      <= '0;
            attempt_cnt   <= '0;
            bitslip_count <= '0;
            adc_data_out  <= '0;
        end else begin
            adc_data_out <= adc_data_in;

            if (state == S_RESET) begin
                wait_cnt <= WAIT_W'(SERDES_WAIT);
            end else if (state == S_WAIT_DLY && idelay_rdy && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            match_cnt  <= (state == S_CHECK && state_next == S_CHECK && frame_match && !restart)
                          ? match_cnt + 1'b1 : '0;
            loss_cnt   <= (state == S_LOCKED && state_next == S_LOCKED && !frame_match)
                          ? loss_cnt + 1'b1 : '0;
            settle_cnt <= (state == S_SETTLE && state_next == S_SETTLE)
                          ? settle_cnt + 1'b1 : '0;

            if (state_next == S_RESET || restart || lock_lost) begin
                attempt_cnt <= '0;
            end else if (state == S_SLIP) begin
                attempt_cnt <= attempt_cnt + 1'b1;
            end

            // The ISERDES keeps its slip position across retrain; only a reset returns it to 0.
            if (state_next == S_RESET) begin
                bitslip_count <= '0;
            end else if (state == S_SLIP) begin
                bitslip_count <= (bitslip_count == CNT_W'(WORD_W - 1)) ? '0 : bitslip_count + 1'b1;
            end
        end
    end

`ifdef SYZYGY_ADC_ALIGN_STATS_EN
    always_ff @(posedge adc_data_clk or posedge reset_async) begin
        if (reset_async) begin
            slip_total <= '0;
            relock_cnt <= '0;
        end else begin
            if (state == S_SLIP && slip_total != 16'hFFFF) slip_total <= slip_total + 16'd1;
            if (lock_lost && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_syzygy_adc_align_ctrl.sv
// Randomized self-checking bench for syzygy_adc_align_ctrl with a behavioural ISERDES/frame model.
// Builds with or without SYZYGY_ADC_ALIGN_STATS_EN.
module tb_syzygy_adc_align_ctrl;

    localparam int          NUM_CH      = 2;
    localparam int          WORD_W      = 16;
    localparam logic [15:0] FRAME       = 16'hFF00;
    localparam int          SERDES_WAIT = 64;
    localparam int          SETTLE_CYC  = 4;
    localparam int          MATCH_CNT   = 4;
    localparam int          LOSS_CNT    = 4;
    // A slip attempt costs the pulse, the settle wait and one compare cycle.
    localparam int          SLIP_PERIOD = SETTLE_CYC + 2;

    logic                     adc_data_clk;
    logic                     reset_async;
    logic                     mmcm_locked;
    logic                     idelay_rdy;
    logic [WORD_W-1:0]        frame_word;
    logic [NUM_CH*WORD_W-1:0] adc_data_in;
    logic                     retrain;
    logic                     reset_sync;
    logic                     reset_idelay;
    logic                     bitslip;
    logic [3:0]               bitslip_count;
    logic                     rdy;
    logic [NUM_CH*WORD_W-1:0] adc_data_out;
    logic                     data_valid;
    logic                     align_err;
`ifdef SYZYGY_ADC_ALIGN_STATS_EN
    logic [15:0]              slip_total;
    logic [7:0]               relock_cnt;
`endif

    syzygy_adc_align_ctrl #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .FRAME_PATTERN(FRAME), .SERDES_WAIT(SERDES_WAIT),
        .SETTLE_CYC(SETTLE_CYC), .MATCH_CNT(MATCH_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .adc_data_clk(adc_data_clk),
        .reset_async(reset_async),
        .mmcm_locked(mmcm_locked),
        .idelay_rdy(idelay_rdy),
        .frame_word(frame_word),
        .adc_data_in(adc_data_in),
        .retrain(retrain),
        .reset_sync(reset_sync),
        .reset_idelay(reset_idelay),
        .bitslip(bitslip),
        .bitslip_count(bitslip_count),
        .rdy(rdy),
        .adc_data_out(adc_data_out),
        .data_valid(data_valid),
`ifdef SYZYGY_ADC_ALIGN_STATS_EN
        .slip_total(slip_total),
        .relock_cnt(relock_cnt),
`endif
        .align_err(align_err)
    );

    initial adc_data_clk = 1'b0;
    always #5 adc_data_clk = ~adc_data_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int slip_pos = 0;
    int target = 0;
    int pulses_total = 0;
    bit corrupt = 0;
    bit bad = 0;
    bit fixed_data = 0;
    bit prev_bs = 0;
    logic [NUM_CH*WORD_W-1:0] exp_q[$];
    int pulse_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame lane as seen through an ISERDES whose word boundary moves one bit per slip.
    function automatic logic [15:0] frame_model();
        logic [31:0] dbl;
        int sh;
        if (corrupt || bad) return 16'h1234;
        sh  = (((slip_pos - target) % WORD_W) + WORD_W) % WORD_W;
        dbl = {FRAME, FRAME};
        dbl = dbl >> sh;
        return dbl[15:0];
    endfunction

    task automatic tick();
        @(negedge adc_data_clk);
        cyc++;
        if (exp_q.size() != 0) check_val("adc_data_out", adc_data_out, exp_q.pop_front());
        if (bitslip) begin
            check_val("bitslip_spacing", prev_bs, 0);
            pulse_q.push_back(cyc);
            slip_pos++;
            pulses_total++;
        end
        prev_bs = bitslip;
        if (reset_sync) slip_pos = 0;
        frame_word  = frame_model();
        adc_data_in = fixed_data ? 32'h1234_ABCD : $urandom;
        exp_q.push_back(adc_data_in);
    endtask

    task automatic wait_rdy(input string tag, input int t0, input int extra, output int r);
        int n = 0;
        while (!rdy && n < 400) begin
            tick();
            n++;
        end
        r = cyc;
        check_val(tag, cyc - t0, SERDES_WAIT + 2 + extra);
    endtask

    task automatic run_train(input string tag, input int r, input int k, input int start_cnt,
                             input bit expect_err);
        int n = 0;
        int t_end;
        pulse_q.delete();
        while (!data_valid && !align_err && n < 500) begin
            tick();
            n++;
        end
        t_end = expect_err ? r + (WORD_W - 1) * SLIP_PERIOD + 2 : r + k * SLIP_PERIOD + MATCH_CNT;
        check_val($sformatf("%s_pulses", tag), pulse_q.size(), k);
        for (int j = 0; j < k && j < pulse_q.size(); j++) begin
            check_val($sformatf("%s_pulse%0d_time", tag, j), pulse_q[j] - r, 1 + j * SLIP_PERIOD);
        end
        check_val($sformatf("%s_end_time", tag), cyc - r, t_end - r);
        check_val($sformatf("%s_data_valid", tag), data_valid, !expect_err);
        check_val($sformatf("%s_align_err", tag), align_err, expect_err);
        check_val($sformatf("%s_bitslip_count", tag), bitslip_count, (start_cnt + k) % WORD_W);
    endtask

    initial begin
        int t0;
        int r;
        int freeze;
        reset_async = 1'b1;
        mmcm_locked = 1'b0;
        idelay_rdy  = 1'b0;
        frame_word  = '0;
        adc_data_in = '0;
        retrain     = 1'b0;
        repeat (3) @(negedge adc_data_clk);

        check_val("rst_reset_sync", reset_sync, 1);
        check_val("rst_reset_idelay", reset_idelay, 1);
        check_val("rst_rdy", rdy, 0);
        check_val("rst_bitslip", bitslip, 0);
        check_val("rst_data_valid", data_valid, 0);
        check_val("rst_align_err", align_err, 0);
        check_val("rst_bitslip_count", bitslip_count, 0);
        check_val("rst_adc_data_out", adc_data_out, 0);

        // Aligned from the start: no slips, lock MATCH_CNT cycles after rdy.
        mmcm_locked = 1'b1;
        idelay_rdy  = 1'b1;
        target      = 0;
        frame_word  = frame_model();
        adc_data_in = $urandom;
        exp_q.push_back(adc_data_in);
        reset_async = 1'b0;
        t0 = cyc;
        tick();
        check_val("release_reset_sync", reset_sync, 0);
        check_val("release_reset_idelay", reset_idelay, 0);
        wait_rdy("rdy_after_reset", t0, 0, r);
        run_train("aligned", r, 0, 0, 0);

        fixed_data = 1;
        tick();
        fixed_data = 0;
        tick();
        check_val("adc_data_fixed", adc_data_out, 32'h1234_ABCD);

        // Three misses then a match keep lock; four misses in a row lose it.
        corrupt = 1;
        repeat (3) tick();
        corrupt = 0;
        tick();
        check_val("dv_hold_3miss", data_valid, 1);
        tick();
        check_val("dv_after_match", data_valid, 1);
        corrupt = 1;
        repeat (4) tick();
        check_val("dv_hold_before_4th", data_valid, 1);
        corrupt = 0;
        tick();
        check_val("dv_drop_4th", data_valid, 0);
        check_val("rdy_kept_on_loss", rdy, 1);
        r = cyc;
        run_train("reacquire", r, 0, 0, 0);

        // Retrain onto a boundary three slips away.
        target  = 3;
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        r = cyc;
        run_train("slip3", r, 3, 0, 0);

        // Clock loss while locked, then the full sequence again with a frozen IDELAYCTRL.
        mmcm_locked = 1'b0;
        idelay_rdy  = 1'b0;
        tick();
        check_val("loss_reset_sync", reset_sync, 1);
        check_val("loss_reset_idelay", reset_idelay, 1);
        check_val("loss_rdy", rdy, 0);
        check_val("loss_data_valid", data_valid, 0);
        check_val("loss_bitslip_count", bitslip_count, 0);
        tick();
        tick();
        target      = $urandom_range(1, 6);
        mmcm_locked = 1'b1;
        idelay_rdy  = 1'b1;
        t0 = cyc;
        repeat (5) tick();
        freeze     = $urandom_range(1, 6);
        idelay_rdy = 1'b0;
        repeat (freeze) tick();
        idelay_rdy = 1'b1;
        wait_rdy("rdy_after_relock", t0, freeze, r);
        run_train("relock", r, target, 0, 0);

        // Frame never matches: every position is tried, then the controller parks in error.
        mmcm_locked = 1'b0;
        tick();
        tick();
        bad         = 1;
        mmcm_locked = 1'b1;
        t0 = cyc;
        wait_rdy("rdy_before_exhaust", t0, 0, r);
        run_train("exhaust", r, WORD_W, 0, 1);
        pulse_q.delete();
        repeat (10) tick();
        check_val("error_hold", align_err, 1);
        check_val("error_no_slip", pulse_q.size(), 0);
        bad     = 0;
        target  = 0;
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        check_val("retrain_clears_err", align_err, 0);
        r = cyc;
        run_train("after_retrain", r, 0, 0, 0);

`ifdef SYZYGY_ADC_ALIGN_STATS_EN
        check_val("slip_total", slip_total, pulses_total);
        check_val("relock_cnt", relock_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
